// File: rtl/dht_pkg.sv
// Shared definitions for the DHT sensor controller: FSM states, protocol
// cycle counts (expressed at 100 MHz and rescaled to CLK_HZ), and the
// 7-segment glyph decoder.
package dht_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    START_HIGH,
    RESP_WAIT_LOW,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } dht_state_e;

  // Cycle counts at a 100 MHz reference clock.
  localparam int START_LOW_CYC  = 1_900_000;   // 19 ms host start low
  localparam int START_HIGH_CYC = 2_000;       // 20 us host start high
  localparam int BIT_THRESH_CYC = 4_000;       // 40 us: longer high time = '1'
  localparam int TIMEOUT_CYC    = 10_000;      // 100 us without a line edge
  localparam int SCAN_CYC       = 100_000;     // 1 ms per display digit
  localparam int AUTO_CYC       = 200_000_000; // 2 s self-trigger period

  // Rescale a 100 MHz cycle count to the actual clock frequency.
  function automatic int scale_cyc(input int cyc_at_100mhz, input int clk_hz);
    longint prod;
    prod = longint'(cyc_at_100mhz) * longint'(clk_hz);
    return int'(prod / longint'(100_000_000));
  endfunction

  // Active-low segments {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/dht_sensor_top_seg7_mux.sv
// Four-digit multiplexed 7-segment driver. Left pair shows int_byte_i mod 100,
// right pair shows dec_byte_i mod 100. One digit is lit per SCAN_N cycles,
// rotating anode bit 0 -> 3. Anode and segment outputs are registered.
module seg7_mux
  import dht_pkg::*;
#(
  parameter int SCAN_N = 100_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] int_byte_i,
  input  logic [7:0] dec_byte_i,
  output logic [6:0] seg_o,
  output logic [3:0] anode_o
);

  localparam int SCAN_W = $clog2(SCAN_N);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_N - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        digit_q, digit_d;
  logic [3:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        int_tens, int_ones, dec_tens, dec_ones, digit_val;

  // Scan timer, digit selection and byte-to-decimal-digit split.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end
    int_tens = 4'((int_byte_i % 8'd100) / 8'd10);
    int_ones = 4'(int_byte_i % 8'd10);
    dec_tens = 4'((dec_byte_i % 8'd100) / 8'd10);
    dec_ones = 4'(dec_byte_i % 8'd10);
    case (digit_q)
      2'd0:    digit_val = dec_ones;
      2'd1:    digit_val = dec_tens;
      2'd2:    digit_val = int_ones;
      default: digit_val = int_tens;
    endcase
    anode_d = ~(4'b0001 << digit_q);
    seg_d   = seg_glyph(digit_val);
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_cnt_q <= '0;
      digit_q    <= 2'd0;
      anode_q    <= 4'b1110;
      seg_q      <= 7'b1000000;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign seg_o   = seg_q;
  assign anode_o = anode_q;

endmodule

// File: rtl/dht_sensor_top.sv
// DHT single-wire sensor controller. A button rising edge (synchronized) runs
// one measurement: host start pulse, sensor response, 40 data bits MSB first,
// checksum verification. Valid readings are shown on a 4-digit display.
// Optional feature macro: DHT_AUTO_TRIGGER_EN adds a 2 s self-trigger in IDLE.
//
// Line handshake: the block owns DTH only in START_LOW/START_HIGH (registered
// enable and value); in every other state the line is released to the
// pull-up and only observed through a 2-FF synchronizer.
module dht_sensor_top
  import dht_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        DTH,
  input  logic       button,
  input  logic       sw_h_t_select,
  output logic       error,
  output logic [6:0] led_7seg_o,
  output logic [3:0] anode_o
);

  localparam int START_LOW_N  = scale_cyc(START_LOW_CYC, CLK_HZ);
  localparam int START_HIGH_N = scale_cyc(START_HIGH_CYC, CLK_HZ);
  localparam int THRESH_N     = scale_cyc(BIT_THRESH_CYC, CLK_HZ);
  localparam int TIMEOUT_N    = scale_cyc(TIMEOUT_CYC, CLK_HZ);
  localparam int SCAN_N       = scale_cyc(SCAN_CYC, CLK_HZ);
  localparam int CNT_W        = $clog2(START_LOW_N + 1);

  localparam logic [CNT_W-1:0] START_LOW_LAST  = CNT_W'(START_LOW_N - 1);
  localparam logic [CNT_W-1:0] START_HIGH_LAST = CNT_W'(START_HIGH_N - 1);
  localparam logic [CNT_W-1:0] THRESH_V        = CNT_W'(THRESH_N);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST    = CNT_W'(TIMEOUT_N - 1);

  dht_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] shift_q, shift_d;
  logic        err_q, err_d;
  logic        oe_q, oe_d, out_q, out_d;
  logic        upd;
  logic [7:0]  sum;
  logic        wait_st;
  logic [7:0]  hum_int_q, hum_dec_q, tmp_int_q, tmp_dec_q;
  logic        btn_meta_q, btn_sync_q, btn_prev_q, btn_rise;
  logic        dth_meta_q, dth_sync_q, dth_prev_q, dth_rise, dth_fall;
  logic        auto_go;

  assign DTH = oe_q ? out_q : 1'bz;

  // Input synchronizers and edge-detect history for button and data line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      dth_meta_q <= 1'b1;
      dth_sync_q <= 1'b1;
      dth_prev_q <= 1'b1;
    end else begin
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      dth_meta_q <= DTH;
      dth_sync_q <= dth_meta_q;
      dth_prev_q <= dth_sync_q;
    end
  end

  assign btn_rise = btn_sync_q & ~btn_prev_q;
  assign dth_rise = dth_sync_q & ~dth_prev_q;
  assign dth_fall = ~dth_sync_q & dth_prev_q;

`ifdef DHT_AUTO_TRIGGER_EN
  localparam int AUTO_N = scale_cyc(AUTO_CYC, CLK_HZ);
  localparam int AUTO_W = $clog2(AUTO_N);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_N - 1);
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

  // Self-trigger period counter, running only while idle.
  always_comb begin
    auto_cnt_d = auto_cnt_q + AUTO_W'(1);
    if (state_q != IDLE || auto_cnt_q == AUTO_LAST) auto_cnt_d = '0;
  end

  // Self-trigger counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) auto_cnt_q <= '0;
    else      auto_cnt_q <= auto_cnt_d;
  end

  assign auto_go = (state_q == IDLE) && (auto_cnt_q == AUTO_LAST);
`else
  assign auto_go = 1'b0;
`endif

  assign sum = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  // Protocol FSM next-state, bit capture, error and line-driver decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    err_d     = err_q;
    upd       = 1'b0;
    wait_st   = (state_q == RESP_WAIT_LOW) || (state_q == RESP_LOW) ||
                (state_q == RESP_HIGH) || (state_q == BIT_LOW) ||
                (state_q == BIT_HIGH);
    case (state_q)
      IDLE: if (btn_rise || auto_go) begin
        state_d = START_LOW;
        err_d   = 1'b0;
      end
      START_LOW:     if (cnt_q == START_LOW_LAST) state_d = START_HIGH;
      START_HIGH:    if (cnt_q == START_HIGH_LAST) state_d = RESP_WAIT_LOW;
      RESP_WAIT_LOW: if (dth_fall) state_d = RESP_LOW;
      RESP_LOW:      if (dth_rise) state_d = RESP_HIGH;
      RESP_HIGH: if (dth_fall) begin
        state_d   = BIT_LOW;
        bit_cnt_d = 6'd0;
      end
      BIT_LOW:       if (dth_rise) state_d = BIT_HIGH;
      BIT_HIGH: if (dth_fall) begin
        // cnt_q restarted on entry to BIT_HIGH, so it holds the high time.
        shift_d = {shift_q[38:0], (cnt_q > THRESH_V)};
        if (bit_cnt_q == 6'd39) begin
          state_d = CHECK;
        end else begin
          state_d   = BIT_LOW;
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      CHECK: begin
        if (sum == shift_q[7:0]) upd = 1'b1;
        else                     err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Sensor silent too long: give up and release the line.
    if (wait_st && !(dth_rise || dth_fall) && cnt_q == TIMEOUT_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    if (state_d != state_q || (wait_st && (dth_rise || dth_fall))) cnt_d = '0;
    oe_d  = (state_d == START_LOW) || (state_d == START_HIGH);
    out_d = (state_d == START_HIGH);
  end

  // FSM, counters, shift register and registered line driver.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 6'd0;
      shift_q   <= '0;
      err_q     <= 1'b0;
      oe_q      <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
    end
  end

  // Latest reading that passed its checksum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hum_int_q <= 8'd0;
      hum_dec_q <= 8'd0;
      tmp_int_q <= 8'd0;
      tmp_dec_q <= 8'd0;
    end else if (upd) begin
      hum_int_q <= shift_q[39:32];
      hum_dec_q <= shift_q[31:24];
      tmp_int_q <= shift_q[23:16];
      tmp_dec_q <= shift_q[15:8];
    end
  end

  assign error = err_q;

  seg7_mux #(
    .SCAN_N (SCAN_N)
  ) u_seg7_mux (
    .clk_i      (clk),
    .rst_ni     (rst),
    .int_byte_i (sw_h_t_select ? tmp_int_q : hum_int_q),
    .dec_byte_i (sw_h_t_select ? tmp_dec_q : hum_dec_q),
    .seg_o      (led_7seg_o),
    .anode_o    (anode_o)
  );

endmodule

// File: tb/tb_dht_sensor_top.sv
// Bench for dht_sensor_top at a reduced clock (CLK_HZ = 250 kHz, 4 us/cycle):
// start low 4750 cycles, start high 5, bit threshold 10, timeout 25,
// display scan 250 cycles per digit.
module tb_dht_sensor_top;

  localparam int CLK_HZ = 250_000;
  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [39:0] frame;
    int          press_bit;
    logic        exp_err;
    string       exp_h;
    string       exp_t;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button = 1'b0;
  logic sel = 1'b0;
  logic sens_low = 1'b0;
  logic error;
  logic [6:0] seg;
  logic [3:0] anode;
  wire dth;

  always #5 clk = ~clk;

  assign dth = sens_low ? 1'b0 : 1'bz;
  pullup (dth);

  dht_sensor_top #(.CLK_HZ(CLK_HZ)) dut (
    .clk           (clk),
    .rst           (rst),
    .DTH           (dth),
    .button        (button),
    .sw_h_t_select (sel),
    .error         (error),
    .led_7seg_o    (seg),
    .anode_o       (anode)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int m_hum_int = 0, m_hum_dec = 0, m_tmp_int = 0, m_tmp_dec = 0;

  function automatic logic model_update(input logic [39:0] f);
    int b[5];
    for (int i = 0; i < 5; i++) b[i] = int'(f[39 - 8*i -: 8]);
    if ((b[0] + b[1] + b[2] + b[3]) % 256 == b[4]) begin
      m_hum_int = b[0]; m_hum_dec = b[1];
      m_tmp_int = b[2]; m_tmp_dec = b[3];
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic string model_str(input int ip, input int dp);
    return $sformatf("%02d%02d", ip % 100, dp % 100);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_anode(input logic [3:0] tgt, output logic ok);
    int n;
    n = 0;
    while (anode == tgt && n < 1300) begin tick(1); n++; end
    while (anode != tgt && n < 1300) begin tick(1); n++; end
    ok = (anode == tgt);
  endtask

  // Walk the four digits, toggling the select while each digit is lit.
  task automatic check_display(input string tag, input string eh, input string et);
    logic ok;
    logic [3:0] tgt;
    byte c;
    for (int d = 0; d < 4; d++) begin
      tgt = ~(4'b0001 << d);
      wait_anode(tgt, ok);
      check($sformatf("%s_scan_d%0d", tag, d), ok, 1);
      sel = 1'b0; tick(3);
      c = eh[3 - d];
      check($sformatf("%s_hum_d%0d", tag, d), seg, GLYPH[int'(c) - 48]);
      sel = 1'b1; tick(3);
      c = et[3 - d];
      check($sformatf("%s_tmp_d%0d", tag, d), seg, GLYPH[int'(c) - 48]);
    end
    sel = 1'b0;
  endtask

  // Button press, then measure the host start pulse until the line is released.
  task automatic start_meas(input string tag);
    int n;
    button = 1'b1; tick(2); button = 1'b0;
    n = 0;
    while (dth != 1'b0 && n < 30) begin tick(1); n++; end
    check({tag, "_start_seen"}, dth, 0);
    check({tag, "_err_clear"}, error, 0);
    n = 0;
    while (dth == 1'b0 && n < 6000) begin tick(1); n++; end
    check_rng({tag, "_low_cyc"}, n, 4500, 4800);
    n = 0;
    while (dut.oe_q && n < 30) begin tick(1); n++; end
    check_rng({tag, "_high_cyc"}, n, 4, 6);
    check({tag, "_line_idle"}, dth, 1);
  endtask

  // Sensor side: response, 40 bits MSB first, end pulse. Optional button
  // press held through bit press_bit.
  task automatic send_frame(input logic [39:0] frame, input int press_bit);
    tick(6);
    sens_low = 1'b1; tick(20);
    sens_low = 1'b0; tick(20);
    for (int i = 39; i >= 0; i--) begin
      sens_low = 1'b1;
      if (39 - i == press_bit) button = 1'b1;
      tick(12);
      sens_low = 1'b0;
      tick(frame[i] ? 18 : 6);
      button = 1'b0;
    end
    sens_low = 1'b1; tick(12);
    sens_low = 1'b0; tick(20);
  endtask

  // Watchdog so the run always ends.
  initial begin
    repeat (150_000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    vec_t vecs [4];
    logic exp_err;
    logic [39:0] frame;
    logic [7:0] b0, b1, b2, b3, ck;
    int n;

    vecs[0] = '{frame: 40'h49521B2DE3, press_bit: -1, exp_err: 1'b0, exp_h: "7382", exp_t: "2745"};
    vecs[1] = '{frame: 40'h49521B2DE4, press_bit: -1, exp_err: 1'b1, exp_h: "7382", exp_t: "2745"};
    vecs[2] = '{frame: 40'h0C630550C4, press_bit: 10, exp_err: 1'b0, exp_h: "1299", exp_t: "0580"};
    vecs[3] = '{frame: 40'hC87B9601DA, press_bit: 25, exp_err: 1'b0, exp_h: "0023", exp_t: "5001"};

    // Reset state.
    rst = 1'b0;
    tick(10);
    check("rst_error", error, 0);
    check("rst_oe", dut.oe_q, 0);
    check("rst_line", dth, 1);
    check("rst_anode", anode, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    rst = 1'b1;
    n = 0;
    while (anode == 4'b1110 && n < 400) begin tick(1); n++; end
    check_rng("scan_period", n, 249, 252);
    check("scan_next", anode, 4'b1101);
    check_display("rst", "0000", "0000");

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      start_meas($sformatf("vec%0d", v));
      send_frame(vecs[v].frame, vecs[v].press_bit);
      exp_err = model_update(vecs[v].frame);
      check($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
      check_display($sformatf("vec%0d", v), vecs[v].exp_h, vecs[v].exp_t);
    end

    // No response: timeout after the release, then a new press recovers.
    start_meas("tmo");
    tick(10);
    check("tmo_early", error, 0);
    tick(30);
    check("tmo_error", error, 1);
    check("tmo_line", dth, 1);
    frame = 40'h3C0A190532; // 60+10+25+5 = 100 = 0x64 -> bad checksum? recompute below
    frame[7:0] = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    start_meas("recov");
    send_frame(frame, -1);
    exp_err = model_update(frame);
    check("recov_error", error, exp_err);
    check_display("recov", model_str(m_hum_int, m_hum_dec), model_str(m_tmp_int, m_tmp_dec));

    // Reset in the middle of the start pulse.
    button = 1'b1; tick(2); button = 1'b0;
    n = 0;
    while (dth != 1'b0 && n < 30) begin tick(1); n++; end
    check("abort_start_seen", dth, 0);
    tick(100);
    rst = 1'b0;
    #1;
    check("abort_oe", dut.oe_q, 0);
    check("abort_line", dth, 1);
    check("abort_anode", anode, 4'b1110);
    tick(3);
    rst = 1'b1;
    m_hum_int = 0; m_hum_dec = 0; m_tmp_int = 0; m_tmp_dec = 0;
    check_display("abort", "0000", "0000");

    // Randomized frames against the model.
    for (int r = 0; r < 2; r++) begin
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      b3 = 8'($urandom_range(0, 255));
      ck = b0 + b1 + b2 + b3;
      if (r != 0 && $urandom_range(0, 1) == 1) ck = ck + 8'($urandom_range(1, 255));
      frame = {b0, b1, b2, b3, ck};
      start_meas($sformatf("rnd%0d", r));
      send_frame(frame, int'($urandom_range(0, 39)));
      exp_err = model_update(frame);
      check($sformatf("rnd%0d_error", r), error, exp_err);
      check_display($sformatf("rnd%0d", r), model_str(m_hum_int, m_hum_dec),
                    model_str(m_tmp_int, m_tmp_dec));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
